// File: rtl/divisor_secuencial.sv
// Sequential signed divider: 16-bit dividend / 8-bit divisor -> 8-bit quotient and remainder.
// Restoring algorithm on magnitudes, one quotient bit per clock, sign fix-up and range check at the end.
module divisor_secuencial (
   input  logic        clk,
   input  logic        reset,
   input  logic        inicio,
   input  logic [15:0] dividendo,
   input  logic [7:0]  divisor,
   output logic [7:0]  cociente,
   output logic [7:0]  residuo,
   output logic        ocupado,
   output logic        listo,
   output logic        error
);

   typedef enum logic [1:0] {
      INACTIVO = 2'd0,
      DIVIDE   = 2'd1,
      AJUSTE   = 2'd2
   } estado_t;

   estado_t     estado_q, estado_d;
   logic [15:0] dvd_q, dvd_d;
   logic [7:0]  dsr_q, dsr_d;
   logic        sgn_dvd_q, sgn_dvd_d;
   logic        sgn_dsr_q, sgn_dsr_d;
   logic        cero_q, cero_d;
   logic [7:0]  rem_q, rem_d;
   logic [15:0] quo_q, quo_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  cociente_q, cociente_d;
   logic [7:0]  residuo_q, residuo_d;
   logic        error_q, error_d;
   logic        listo_q, listo_d;

   logic [8:0]  trial_s;
   logic [7:0]  resta_s;
   logic        cabe_s;
   logic        quo_neg_s;
   logic [7:0]  quo_sgn_s;
   logic [7:0]  rem_sgn_s;
   logic        desborde_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q   <= INACTIVO;
         dvd_q      <= '0;
         dsr_q      <= '0;
         sgn_dvd_q  <= 1'b0;
         sgn_dsr_q  <= 1'b0;
         cero_q     <= 1'b0;
         rem_q      <= '0;
         quo_q      <= '0;
         cnt_q      <= '0;
         cociente_q <= '0;
         residuo_q  <= '0;
         error_q    <= 1'b0;
         listo_q    <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         dvd_q      <= dvd_d;
         dsr_q      <= dsr_d;
         sgn_dvd_q  <= sgn_dvd_d;
         sgn_dsr_q  <= sgn_dsr_d;
         cero_q     <= cero_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         cnt_q      <= cnt_d;
         cociente_q <= cociente_d;
         residuo_q  <= residuo_d;
         error_q    <= error_d;
         listo_q    <= listo_d;
      end
   end

   // Datapath helpers. The partial remainder stays below |divisor| <= 128, so when the
   // trial fits, the low 8 bits of the subtraction are exact.
   always_comb begin
      trial_s    = {rem_q, dvd_q[15]};
      cabe_s     = (trial_s >= {1'b0, dsr_q});
      resta_s    = trial_s[7:0] - dsr_q;
      quo_neg_s  = sgn_dvd_q ^ sgn_dsr_q;
      quo_sgn_s  = quo_neg_s ? (~quo_q[7:0] + 8'd1) : quo_q[7:0];
      rem_sgn_s  = sgn_dvd_q ? (~rem_q + 8'd1) : rem_q;
      // Negative side reaches one further: magnitude 128 is still representable.
      desborde_s = quo_neg_s ? (quo_q > 16'd128) : (quo_q > 16'd127);
   end

   always_comb begin
      estado_d   = estado_q;
      dvd_d      = dvd_q;
      dsr_d      = dsr_q;
      sgn_dvd_d  = sgn_dvd_q;
      sgn_dsr_d  = sgn_dsr_q;
      cero_d     = cero_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      cnt_d      = cnt_q;
      cociente_d = cociente_q;
      residuo_d  = residuo_q;
      error_d    = error_q;
      listo_d    = 1'b0;

      case (estado_q)
         INACTIVO: begin
            if (inicio) begin
               dvd_d     = dividendo[15] ? (~dividendo + 16'd1) : dividendo;
               dsr_d     = divisor[7] ? (~divisor + 8'd1) : divisor;
               sgn_dvd_d = dividendo[15];
               sgn_dsr_d = divisor[7];
               rem_d     = '0;
               quo_d     = '0;
               cnt_d     = '0;
               cero_d    = (divisor == 8'd0);
               estado_d  = (divisor == 8'd0) ? AJUSTE : DIVIDE;
            end
         end
         DIVIDE: begin
            rem_d = cabe_s ? resta_s : trial_s[7:0];
            quo_d = {quo_q[14:0], cabe_s};
            dvd_d = {dvd_q[14:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               estado_d = AJUSTE;
            end
         end
         AJUSTE: begin
            listo_d  = 1'b1;
            estado_d = INACTIVO;
            if (cero_q) begin
               cociente_d = 8'h00;
               residuo_d  = 8'h00;
               error_d    = 1'b1;
            end else if (desborde_s) begin
               cociente_d = quo_neg_s ? 8'h80 : 8'h7F;
               residuo_d  = rem_sgn_s;
               error_d    = 1'b1;
            end else begin
               cociente_d = quo_sgn_s;
               residuo_d  = rem_sgn_s;
               error_d    = 1'b0;
            end
         end
         default: begin
            estado_d = INACTIVO;
         end
      endcase
   end

   assign ocupado  = (estado_q != INACTIVO);
   assign cociente = cociente_q;
   assign residuo  = residuo_q;
   assign error    = error_q;
   assign listo    = listo_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Scoreboard bench for divisor_secuencial: stimulus pushes expectations, a monitor pops on listo.
module tb_divisor_secuencial;

   logic        clk = 1'b0;
   logic        reset;
   logic        inicio;
   logic [15:0] dividendo;
   logic [7:0]  divisor;
   logic [7:0]  cociente;
   logic [7:0]  residuo;
   logic        ocupado;
   logic        listo;
   logic        error;

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       e;
      int         lat;
      int         acc;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  b;
      logic [7:0]  q;
      logic [7:0]  r;
      logic        e;
      int          lat;
   } dir_t;

   exp_t sb[$];
   int   listo_cycs[$];
   dir_t dirs[9];

   divisor_secuencial dut (
      .clk(clk), .reset(reset), .inicio(inicio), .dividendo(dividendo), .divisor(divisor),
      .cociente(cociente), .residuo(residuo), .ocupado(ocupado), .listo(listo), .error(error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cyc %0d)", nm, act, req, cyc);
      end
   endtask

   // Reference: plain signed integer division (truncates toward zero, remainder takes dividend sign).
   function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
      exp_t e;
      int sa, sbv, q, r;
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      e.acc = 0;
      if (sbv == 0) begin
         e.q = 8'h00; e.r = 8'h00; e.e = 1'b1; e.lat = 1;
      end else begin
         q = sa / sbv;
         r = sa % sbv;
         e.lat = 17;
         e.r = r[7:0];
         if (q > 127) begin
            e.q = 8'h7F; e.e = 1'b1;
         end else if (q < -128) begin
            e.q = 8'h80; e.e = 1'b1;
         end else begin
            e.q = q[7:0]; e.e = 1'b0;
         end
      end
      return e;
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset && listo) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_listo actual=1 required=0 (cyc %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk("cociente", {24'd0, cociente}, {24'd0, e.q});
            chk("residuo", {24'd0, residuo}, {24'd0, e.r});
            chk("error", {31'd0, error}, {31'd0, e.e});
            chk("latency", cyc - e.acc - 1, e.lat);
            chk("ocupado_at_listo", {31'd0, ocupado}, 32'd0);
            listo_cycs.push_back(cyc);
         end
      end
   end

   task automatic start(input logic [15:0] a, input logic [7:0] b, input exp_t e);
      int n = 0;
      @(negedge clk);
      while (ocupado && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         failures++;
         $display("FAIL start_timeout actual=busy required=idle (cyc %0d)", cyc);
      end
      inicio    = 1'b1;
      dividendo = a;
      divisor   = b;
      e.acc     = cyc;
      sb.push_back(e);
      @(negedge clk);
      inicio    = 1'b0;
      dividendo = 16'($urandom);
      divisor   = 8'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || ocupado) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         checks++;
         failures++;
         $display("FAIL idle_timeout actual=%0d pending required=0", sb.size());
         sb.delete();
      end
   endtask

   function automatic exp_t mk(input logic [7:0] q, input logic [7:0] r, input logic e, input int lat);
      exp_t x;
      x.q = q; x.r = r; x.e = e; x.lat = lat; x.acc = 0;
      return x;
   endfunction

   initial begin
      int n0;
      logic [7:0] x, y;
      int p;
      logic [15:0] a;
      logic [7:0]  b;

      dirs[0] = '{16'hDB90, 8'd88,  8'h96, 8'h00, 1'b0, 17};
      dirs[1] = '{16'h2BE4, 8'h96,  8'h96, 8'h00, 1'b0, 17};
      dirs[2] = '{16'h3E04, 8'h7E,  8'h7E, 8'h00, 1'b0, 17};
      dirs[3] = '{16'hFFF9, 8'h02,  8'hFD, 8'hFF, 1'b0, 17};
      dirs[4] = '{16'h0007, 8'hFE,  8'hFD, 8'h01, 1'b0, 17};
      dirs[5] = '{16'hFF00, 8'h02,  8'h80, 8'h00, 1'b0, 17};
      dirs[6] = '{16'h4000, 8'h02,  8'h7F, 8'h00, 1'b1, 17};
      dirs[7] = '{16'h8000, 8'hFF,  8'h7F, 8'h00, 1'b1, 17};
      dirs[8] = '{16'd1000, 8'h00,  8'h00, 8'h00, 1'b1, 1};

      reset = 1'b1; inicio = 1'b0; dividendo = '0; divisor = '0;
      repeat (2) @(negedge clk);
      chk("reset_cociente", {24'd0, cociente}, 32'd0);
      chk("reset_residuo", {24'd0, residuo}, 32'd0);
      chk("reset_ocupado", {31'd0, ocupado}, 32'd0);
      chk("reset_listo", {31'd0, listo}, 32'd0);
      chk("reset_error", {31'd0, error}, 32'd0);
      reset = 1'b0;

      // Directed cases issued back-to-back.
      for (int i = 0; i < 9; i++)
         start(dirs[i].a, dirs[i].b, mk(dirs[i].q, dirs[i].r, dirs[i].e, dirs[i].lat));
      wait_idle();
      chk("directed_count", listo_cycs.size(), 9);
      if (listo_cycs.size() >= 2)
         chk("back_to_back", listo_cycs[1] - listo_cycs[0], 18);

      // inicio held high, then toggled, while busy: must not start a second operation.
      n0 = listo_cycs.size();
      start(16'd5000, 8'd50, mk(8'h64, 8'h00, 1'b0, 17));
      for (int j = 0; j < 15; j++) begin
         inicio    = (j < 8) ? 1'b1 : 1'($urandom_range(0, 1));
         dividendo = 16'($urandom);
         divisor   = 8'($urandom);
         chk("busy_ocupado", {31'd0, ocupado}, 32'd1);
         @(negedge clk);
      end
      inicio = 1'b0;
      wait_idle();
      repeat (5) @(negedge clk);
      chk("busy_single_result", listo_cycs.size() - n0, 1);

      // Reset in the middle of an operation.
      n0 = listo_cycs.size();
      start(16'd1234, 8'd5, model(16'd1234, 8'd5));
      repeat (7) @(negedge clk);
      reset = 1'b1;
      #1;
      sb.delete();
      chk("midreset_cociente", {24'd0, cociente}, 32'd0);
      chk("midreset_residuo", {24'd0, residuo}, 32'd0);
      chk("midreset_error", {31'd0, error}, 32'd0);
      chk("midreset_ocupado", {31'd0, ocupado}, 32'd0);
      chk("midreset_listo", {31'd0, listo}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (25) @(negedge clk);
      chk("midreset_no_listo", listo_cycs.size() - n0, 0);
      chk("midreset_idle", {31'd0, ocupado}, 32'd0);
      start(16'd100, 8'd7, mk(8'h0E, 8'h02, 1'b0, 17));
      wait_idle();

      // Randomized operands against the arithmetic model.
      for (int i = 0; i < 150; i++) begin
         case (i % 3)
            0: begin
               a = 16'($urandom);
               b = 8'($urandom);
            end
            1: begin
               x = 8'($urandom);
               y = 8'($urandom);
               p = $signed(x) * $signed(y);
               a = p[15:0];
               b = y;
            end
            default: begin
               a = 16'($urandom_range(0, 600)) - 16'd300;
               b = 8'($urandom_range(0, 40)) - 8'd20;
            end
         endcase
         if (i % 10 == 0) b = 8'h00;
         if (i % 17 == 0) b = 8'h80;
         if (i % 23 == 0) a = 16'h8000;
         start(a, b, model(a, b));
      end
      wait_idle();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/divisor_secuencial.md
# divisor_secuencial

Sequential signed divider: a 16-bit two's-complement dividend divided by an 8-bit two's-complement divisor gives an 8-bit signed quotient and an 8-bit signed remainder. It is the inverse of the combinational `multiplicador` (8×8 → 16). It is used to recover a factor from a product and as a self-check partner for the multiplier. It uses a start/done handshake and a multi-cycle restoring algorithm, with one quotient bit resolved per clock.

## Interface
- No parameters; widths fixed at 16/8.
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-high; clears all state and outputs
- inicio  in  1  start request; sampled only while idle
- dividendo  in  16  signed dividend, two's complement
- divisor  in  8  signed divisor, two's complement
- cociente  out  8  signed quotient (truncated toward zero); reset 8'h00
- residuo  out  8  signed remainder, sign follows dividend; reset 8'h00
- ocupado  out  1  high while an operation is in progress; reset 0
- listo  out  1  one-cycle pulse, result valid; reset 0
- error  out  1  divide-by-zero or quotient overflow for the last result; reset 0

One clock; reset is asynchronous and active-high.

## Operation
- States:
  - INACTIVO: idle.
  - DIVIDE: 16 iterations.
  - AJUSTE: sign fix, range check.
  - Return to INACTIVO after AJUSTE.
- INACTIVO, inicio=1 (accept edge):
  - Latch |dividendo| as a 16-bit unsigned value (|−32768| = 0x8000).
  - Latch |divisor| as an 8-bit unsigned value (|−128| = 0x80).
  - Latch both sign bits.
  - Clear the 8-bit partial remainder, the 16-bit quotient and the 4-bit counter.
  - If divisor = 0, go to AJUSTE with a zero flag set; otherwise go to DIVIDE.
- DIVIDE, each cycle:
  - Shift {remainder, quotient} left by 1, shifting in the next dividend MSB. Use a 9-bit trial remainder.
  - If trial ≥ |divisor|: subtract, quotient LSB = 1. Otherwise quotient LSB = 0.
  - After 16 cycles, go to AJUSTE.
- AJUSTE:
  - Quotient negative iff the operand signs differ. Remainder negative iff the dividend is negative. Negate magnitudes accordingly.
  - If the signed quotient is outside [−128, 127]: cociente = 8'h7F if positive, 8'h80 if negative; residuo = signed remainder; error = 1.
  - If the zero flag is set: cociente = 8'h00, residuo = 8'h00, error = 1.
  - Otherwise: cociente = quotient[7:0], residuo = remainder[7:0], error = 0.
  - Pulse listo; go to INACTIVO.
- |remainder| < |divisor| ≤ 128, so residuo always fits 8 bits signed.
- inicio while ocupado = 1 is ignored, not queued.
- cociente, residuo and error are registered. They hold the last result until the next AJUSTE or reset.

## Timing
- Accept at edge k; ocupado = 1 from edge k to edge k+17.
- Normal operation: iterations at edges k+1..k+16; outputs and listo = 1 updated at edge k+17. Latency is 17 cycles.
- Divisor = 0: AJUSTE at edge k+1; listo high for cycle k+1..k+2.
- listo is high for exactly one cycle.
- ocupado falls at the same edge listo rises. A new inicio in that cycle is accepted at the following edge, giving back-to-back throughput of one operation per 18 cycles.
- Reset mid-operation: the current operation is aborted immediately (async). All outputs go to 0 and the state goes to INACTIVO. No listo is produced for the aborted operation.
- Operand changes after the accept edge have no effect.

## Test plan
- Multiplier round trip, case 1: dividendo = −9328 (16'hDB90), divisor = 88 → cociente 8'h96 (−106), residuo 8'h00, error 0. listo exactly 17 cycles after accept.
- Multiplier round trips, cases 2 and 3:
  - 11236 / 8'h96 (−106) → 8'h96, residuo 0.
  - 15876 / 126 → 8'h7E, residuo 0.
- Truncation and remainder signs:
  - −7 / 2 → cociente 8'hFD, residuo 8'hFF.
  - 7 / −2 → 8'hFD, 8'h01.
  - −256 / 2 → 8'h80, error 0.
- Overflow and divide-by-zero:
  - 16384 / 2 → 8'h7F, error 1.
  - −32768 / −1 → 8'h7F, error 1.
  - 1000 / 0 → 8'h00, 8'h00, error 1; listo 1 cycle after accept.
- Handshake:
  - inicio held high and pulsed during busy: no second start until ocupado drops.
  - Back-to-back: next listo 18 cycles after the first.
- Reset at iteration 8: outputs cleared, no listo. The next operation (100 / 7 → 8'h0E, residuo 8'h02) completes correctly.
